multicycle_control: RTL

Multicycle control sequencer for the MIPS-subset datapath. It replaces the single-cycle control unit when instruction fetch and data access share one memory port. A Moore FSM walks each instruction through fetch, decode, execute, memory and writeback states, and waits on a memory ready handshake. It drives every datapath mux select, register-file and memory enable, and the PC/IR write strobes.

---
 rtl/mc_pkg.sv | 41 ++++
 rtl/multicycle_control.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control sequencer: state codes,
// supported opcodes and the datapath select encodings.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDI   = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_SEXT   = 2'b10;
  localparam logic [1:0] SRCB_SEXTSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// Moore control sequencer for the shared-memory multicycle MIPS datapath.
// State register with in-block next-state decode; outputs decoded from the
// current state (plus mem_ready for the handshake strobes).
module multicycle_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_q;

  // The zero flag is gated into the PC load by the datapath, not here.
  logic unused_zero;
  assign unused_zero = zero;

  // State register and next-state selection.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:  if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state_q <= S_MEMADR;
            OP_RTYPE:     state_q <= S_EXEC;
            OP_BEQ:       state_q <= S_BRANCH;
            OP_J:         state_q <= S_JUMP;
            OP_ADDI:      state_q <= S_ADDI;
            default:      state_q <= S_TRAP;
          endcase
        end
        S_MEMADR: state_q <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) state_q <= S_MEMWB;
        S_MEMWB:  state_q <= S_FETCH;
        S_MEMWR:  if (mem_ready) state_q <= S_FETCH;
        S_EXEC:   state_q <= S_RWB;
        S_RWB:    state_q <= S_FETCH;
        S_BRANCH: state_q <= S_FETCH;
        S_ADDI:   state_q <= S_ADDIWB;
        S_ADDIWB: state_q <= S_FETCH;
        S_JUMP:   state_q <= S_FETCH;
        S_TRAP:   state_q <= S_TRAP;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  // Output decode; reset overrides everything so no strobe escapes the reset cycle.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    state         = state_q;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = SRCB_SEXTSH;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_SEXT;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        instr_done    = 1'b1;
      end
      S_ADDI: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_SEXT;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      S_TRAP:  illegal_op = 1'b1;
      default: ;
    endcase
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = '0;
      alu_op        = '0;
      pc_source     = '0;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;
      state         = '0;
    end
  end

endmodule
